// File: rtl/ring_counter_gen_if.sv
// ring_counter_gen_if: control/status bundle of the ring/Johnson sequencer.
// The controller drives the master side, the counter sits on the slave side.
interface ring_counter_gen_if #(parameter int WIDTH = 4);
    logic             Enable;
    logic             Dir;
    logic             Mode;
    logic             Load;
    logic [WIDTH-1:0] Load_value;
    logic [WIDTH-1:0] Count_out;
    logic             Wrap;
    logic             Err;

    modport master (
        output Enable, Dir, Mode, Load, Load_value,
        input  Count_out, Wrap, Err
    );

    modport slave (
        input  Enable, Dir, Mode, Load, Load_value,
        output Count_out, Wrap, Err
    );
endinterface

// File: rtl/ring_counter_gen.sv
// ring_counter_gen: parametrised one-hot / Johnson ring sequencer with load,
// direction control, illegal-state self-correction and a wrap pulse.
module ring_counter_gen #(
    parameter int WIDTH = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    ring_counter_gen_if.slave bus
);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_err;
    logic [WIDTH-1:0] w_ring_next;
    logic [WIDTH-1:0] w_john_next;
    logic [WIDTH-1:0] w_step;
    logic             w_ring_ok;
    logic             w_john_ok;
    logic             w_legal;

    // Johnson states are runs of ones anchored at either end, all-zeros and all-ones included
    always_comb begin
        w_ring_ok   = $onehot(r_count);
        w_john_ok   = ((r_count & (r_count + SEED)) == '0) || ((~r_count & (~r_count + SEED)) == '0);
        w_ring_next = bus.Dir ? {r_count[0], r_count[WIDTH-1:1]} : {r_count[WIDTH-2:0], r_count[WIDTH-1]};
        w_john_next = bus.Dir ? {~r_count[0], r_count[WIDTH-1:1]} : {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
        w_legal     = bus.Mode ? w_john_ok : w_ring_ok;
        w_step      = bus.Mode ? w_john_next : w_ring_next;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count <= SEED;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.Load) begin
            r_count <= bus.Load_value;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else if (bus.Enable) begin
            r_count <= w_legal ? w_step : SEED;
            r_wrap  <= w_legal && (w_step == SEED);
            r_err   <= !w_legal;
        end else begin
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign bus.Count_out = r_count;
    assign bus.Wrap      = r_wrap;
    assign bus.Err       = r_err;
endmodule

// File: tb/tb_ring_counter_gen.sv
// tb_ring_counter_gen: directed vector table, async-reset sequence and a
// randomized run against a sequence-index reference model, at WIDTH 4 and 8.
module tb_ring_counter_gen;
    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    ring_counter_gen_if #(.WIDTH(4)) b4();
    ring_counter_gen_if #(.WIDTH(8)) b8();

    ring_counter_gen #(.WIDTH(4)) dut4 (.Clock(Clock), .Reset(Reset), .bus(b4));
    ring_counter_gen #(.WIDTH(8)) dut8 (.Clock(Clock), .Reset(Reset), .bus(b8));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string    name;
        bit       ld, en, mode, dir;
        logic [3:0] lv;
        logic [3:0] q;
        bit       wrap, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(string nm, bit ld, bit en, bit mode, bit dir,
                               logic [3:0] lv, logic [3:0] q, bit w, bit e);
        vec_t r;
        r.name = nm; r.ld = ld; r.en = en; r.mode = mode; r.dir = dir;
        r.lv = lv; r.q = q; r.wrap = w; r.err = e;
        return r;
    endfunction

    task automatic chk(string nm, logic [33:0] act, logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got wrap=%0b err=%0b q=%h, want wrap=%0b err=%0b q=%h",
                     nm, act[33], act[32], act[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic drive4(bit ld, bit en, bit mode, bit dir, logic [3:0] lv);
        b4.Load = ld; b4.Enable = en; b4.Mode = mode; b4.Dir = dir; b4.Load_value = lv;
    endtask

    task automatic drive8(bit ld, bit en, bit mode, bit dir, logic [7:0] lv);
        b8.Load = ld; b8.Enable = en; b8.Mode = mode; b8.Dir = dir; b8.Load_value = lv;
    endtask

    // k-th Johnson state counting from all-zeros: fill ones from the LSB, then drain them from the LSB
    function automatic logic [31:0] jseq(int n, int k);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        if (k <= n) return 32'((64'd1 << k) - 64'd1);
        return 32'(m & ~((64'd1 << (k - n)) - 64'd1));
    endfunction

    // Reference: ring state = position of the single one, Johnson state = index into jseq
    function automatic logic [33:0] ref_step(int n, logic [31:0] q, bit ld, bit en,
                                             bit mode, bit dir, logic [31:0] lv);
        logic [31:0] mask, nq;
        int idx;
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        if (ld) return {2'b00, lv & mask};
        if (!en) return {2'b00, q};
        idx = -1;
        if (!mode) begin
            if ($countones(q) == 1)
                for (int b = 0; b < n; b++) if (q[b]) idx = b;
            if (idx < 0) return {2'b01, 32'd1};
            nq = 32'd1 << (dir ? (idx + n - 1) % n : (idx + 1) % n);
        end else begin
            for (int k = 0; k < 2 * n; k++) if (jseq(n, k) == q) idx = k;
            if (idx < 0) return {2'b01, 32'd1};
            nq = jseq(n, dir ? (idx + 2 * n - 1) % (2 * n) : (idx + 1) % (2 * n));
        end
        return {(nq == 32'd1), 1'b0, nq};
    endfunction

    initial begin
        logic [33:0] m4, m8;
        bit md4, md8, dr4, dr8;
        int wraps;

        Reset = 1'b1;
        drive4(0, 0, 0, 0, '0);
        drive8(0, 0, 0, 0, '0);
        #12;
        chk("reset4", {b4.Wrap, b4.Err, 32'(b4.Count_out)}, {2'b00, 32'd1});
        chk("reset8", {b8.Wrap, b8.Err, 32'(b8.Count_out)}, {2'b00, 32'd1});
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;
        chk("post_reset4", {b4.Wrap, b4.Err, 32'(b4.Count_out)}, {2'b00, 32'd1});

        vecs.push_back(v("ring_up1",   0, 1, 0, 0, 4'h0, 4'b0010, 0, 0));
        vecs.push_back(v("ring_up2",   0, 1, 0, 0, 4'h0, 4'b0100, 0, 0));
        vecs.push_back(v("ring_up3",   0, 1, 0, 0, 4'h0, 4'b1000, 0, 0));
        vecs.push_back(v("ring_wrap",  0, 1, 0, 0, 4'h0, 4'b0001, 1, 0));
        vecs.push_back(v("hold_seed",  0, 0, 0, 0, 4'h0, 4'b0001, 0, 0));
        vecs.push_back(v("john_up1",   0, 1, 1, 0, 4'h0, 4'b0011, 0, 0));
        vecs.push_back(v("john_up2",   0, 1, 1, 0, 4'h0, 4'b0111, 0, 0));
        vecs.push_back(v("john_up3",   0, 1, 1, 0, 4'h0, 4'b1111, 0, 0));
        vecs.push_back(v("john_up4",   0, 1, 1, 0, 4'h0, 4'b1110, 0, 0));
        vecs.push_back(v("john_up5",   0, 1, 1, 0, 4'h0, 4'b1100, 0, 0));
        vecs.push_back(v("john_up6",   0, 1, 1, 0, 4'h0, 4'b1000, 0, 0));
        vecs.push_back(v("john_up7",   0, 1, 1, 0, 4'h0, 4'b0000, 0, 0));
        vecs.push_back(v("john_wrap",  0, 1, 1, 0, 4'h0, 4'b0001, 1, 0));
        vecs.push_back(v("john_dn1",   0, 1, 1, 1, 4'h0, 4'b0000, 0, 0));
        vecs.push_back(v("john_dn2",   0, 1, 1, 1, 4'h0, 4'b1000, 0, 0));
        vecs.push_back(v("john_dn3",   0, 1, 1, 1, 4'h0, 4'b1100, 0, 0));
        vecs.push_back(v("john_dn4",   0, 1, 1, 1, 4'h0, 4'b1110, 0, 0));
        vecs.push_back(v("john_dn5",   0, 1, 1, 1, 4'h0, 4'b1111, 0, 0));
        vecs.push_back(v("john_dn6",   0, 1, 1, 1, 4'h0, 4'b0111, 0, 0));
        vecs.push_back(v("john_dn7",   0, 1, 1, 1, 4'h0, 4'b0011, 0, 0));
        vecs.push_back(v("john_dnwrap",0, 1, 1, 1, 4'h0, 4'b0001, 1, 0));
        vecs.push_back(v("ring_dn1",   0, 1, 0, 1, 4'h0, 4'b1000, 0, 0));
        vecs.push_back(v("ring_dn2",   0, 1, 0, 1, 4'h0, 4'b0100, 0, 0));
        vecs.push_back(v("ring_dn3",   0, 1, 0, 1, 4'h0, 4'b0010, 0, 0));
        vecs.push_back(v("ring_dnwrap",0, 1, 0, 1, 4'h0, 4'b0001, 1, 0));
        vecs.push_back(v("ld_0110",    1, 0, 0, 0, 4'b0110, 4'b0110, 0, 0));
        vecs.push_back(v("fix_0110",   0, 1, 0, 0, 4'h0, 4'b0001, 0, 1));
        vecs.push_back(v("ld_0000",    1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(v("fix_0000",   0, 1, 0, 0, 4'h0, 4'b0001, 0, 1));
        vecs.push_back(v("err_clear",  0, 0, 0, 0, 4'h0, 4'b0001, 0, 0));
        vecs.push_back(v("to_0010",    0, 1, 0, 0, 4'h0, 4'b0010, 0, 0));
        vecs.push_back(v("to_0100",    0, 1, 0, 0, 4'h0, 4'b0100, 0, 0));
        vecs.push_back(v("mode01_fix", 0, 1, 1, 0, 4'h0, 4'b0001, 0, 1));
        vecs.push_back(v("to_0011",    0, 1, 1, 0, 4'h0, 4'b0011, 0, 0));
        vecs.push_back(v("mode10_fix", 0, 1, 0, 0, 4'h0, 4'b0001, 0, 1));
        vecs.push_back(v("ld_beats_en",1, 1, 0, 0, 4'b1000, 4'b1000, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(v("hold_1000", 0, 0, 0, 0, 4'h0, 4'b1000, 0, 0));
        vecs.push_back(v("ld_1111",    1, 0, 1, 0, 4'b1111, 4'b1111, 0, 0));
        vecs.push_back(v("john_1111",  0, 1, 1, 0, 4'h0, 4'b1110, 0, 0));
        vecs.push_back(v("ld_j0000",   1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(v("j0000_wrap", 0, 1, 1, 0, 4'h0, 4'b0001, 1, 0));

        foreach (vecs[i]) begin
            drive4(vecs[i].ld, vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].lv);
            @(posedge Clock); #1;
            chk(vecs[i].name, {b4.Wrap, b4.Err, 32'(b4.Count_out)},
                {vecs[i].wrap, vecs[i].err, 28'd0, vecs[i].q});
        end

        // WIDTH=8: walk to 00100000, then reset between edges
        drive4(0, 0, 0, 0, '0);
        drive8(0, 1, 0, 0, '0);
        repeat (5) @(posedge Clock);
        #1;
        chk("w8_at_0x20", {b8.Wrap, b8.Err, 32'(b8.Count_out)}, {2'b00, 32'h20});
        #3 Reset = 1'b1;
        #1;
        chk("w8_async_rst", {b8.Wrap, b8.Err, 32'(b8.Count_out)}, {2'b00, 32'd1});
        #2 Reset = 1'b0;
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock); #1;
            wraps += int'(b8.Wrap);
            chk("w8_step", {b8.Wrap, b8.Err, 32'(b8.Count_out)},
                {(i == 7), 1'b0, 32'd1 << ((i + 1) % 8)});
        end
        chk("w8_one_wrap", 34'(wraps), 34'd1);

        // Randomized run from a fresh reset on both widths
        drive8(0, 0, 0, 0, '0);
        @(negedge Clock) Reset = 1'b1;
        @(negedge Clock) Reset = 1'b0;
        m4 = {2'b00, 32'd1};
        m8 = {2'b00, 32'd1};
        md4 = 0; md8 = 0; dr4 = 0; dr8 = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) md4 = !md4;
            if ($urandom_range(0, 15) == 0) md8 = !md8;
            if ($urandom_range(0, 7) == 0) dr4 = !dr4;
            if ($urandom_range(0, 7) == 0) dr8 = !dr8;
            drive4($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, md4, dr4,
                   $urandom_range(0, 1) ? 4'(4'd1 << $urandom_range(0, 3)) : 4'($urandom));
            drive8($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, md8, dr8,
                   $urandom_range(0, 1) ? 8'(8'd1 << $urandom_range(0, 7)) : 8'($urandom));
            @(posedge Clock); #1;
            m4 = ref_step(4, m4[31:0], b4.Load, b4.Enable, b4.Mode, b4.Dir, 32'(b4.Load_value));
            m8 = ref_step(8, m8[31:0], b8.Load, b8.Enable, b8.Mode, b8.Dir, 32'(b8.Load_value));
            chk("rand4", {b4.Wrap, b4.Err, 32'(b4.Count_out)}, m4);
            chk("rand8", {b8.Wrap, b8.Err, 32'(b8.Count_out)}, m8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
